// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter.
// Covers the FSM states, the fill owner and the block geometry.
package cache_fill_arbiter_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned BLOCK_OFF_BITS  = 4;
    localparam int unsigned IDX_W           = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL_ISSUE,
        FILL_DRAIN,
        WRITE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word counter within a block fill.
// Supports synchronous clear and increment, and flags the last word.
module fill_counter
    import cache_fill_arbiter_pkg::*;
#(
    parameter int unsigned LAST = WORDS_PER_BLOCK - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    logic [IDX_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == IDX_W'(LAST));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D block fills and D write-through writes onto a single memory port.
// Reads are pipelined: issue and receive are counted independently.
module cache_fill_arbiter #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [15:0]       d_wr_data,
    input  logic [15:0]       mem_data_out,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data_in,
    output logic [15:0]       fill_data,
    output logic [2:0]        fill_idx,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic              i_done,
    output logic              d_done,
    output logic              d_wr_ack
);

    import cache_fill_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = {ADDR_W{1'b1}} << BLOCK_OFF_BITS;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic             iss_clr, iss_inc, iss_tc;
    logic             rx_clr, rx_inc, rx_tc;
    logic [IDX_W-1:0] iss_cnt, rx_cnt;

    fill_counter #(.LAST(WORDS_PER_BLOCK - 1)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (iss_clr),
        .inc   (iss_inc),
        .count (iss_cnt),
        .tc    (iss_tc)
    );

    fill_counter #(.LAST(WORDS_PER_BLOCK - 1)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_clr),
        .inc   (rx_inc),
        .count (rx_cnt),
        .tc    (rx_tc)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        base_d       = base_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        iss_clr      = 1'b0;
        iss_inc      = 1'b0;
        rx_clr       = 1'b0;
        rx_inc       = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        fill_data    = '0;
        fill_idx     = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        d_wr_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                iss_clr = 1'b1;
                rx_clr  = 1'b1;
                if (d_wr_req) begin
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                    state_d   = WRITE;
                end else if (d_req) begin
                    owner_d = OWN_D;
                    base_d  = d_addr & BLOCK_MASK;
                    state_d = FILL_ISSUE;
                end else if (i_req) begin
                    owner_d = OWN_I;
                    base_d  = i_addr & BLOCK_MASK;
                    state_d = FILL_ISSUE;
                end
            end
            FILL_ISSUE: begin
                mem_enable = 1'b1;
                mem_addr   = base_q + ADDR_W'({iss_cnt, 1'b0});
                iss_inc    = 1'b1;
                if (iss_tc) begin
                    state_d = FILL_DRAIN;
                end
            end
            FILL_DRAIN: begin
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = wr_addr_q;
                mem_data_in = wr_data_q;
                d_wr_ack    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Returning words are accepted in both fill states; with short memory
        // latency the last word can land before issuing finishes, so done wins.
        if ((state_q == FILL_ISSUE || state_q == FILL_DRAIN) && mem_data_valid) begin
            fill_data    = mem_data_out;
            fill_idx     = rx_cnt;
            rx_inc       = 1'b1;
            i_fill_valid = (owner_q == OWN_I);
            d_fill_valid = (owner_q == OWN_D);
            if (rx_tc) begin
                i_done  = (owner_q == OWN_I);
                d_done  = (owner_q == OWN_D);
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: transaction-level expected queue,
// memory model with programmable latency, and a monitor that checks every cycle.
module tb_cache_fill_arbiter;

    localparam int K_I = 0;
    localparam int K_D = 1;
    localparam int K_W = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack;

    cache_fill_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .fill_data      (fill_data),
        .fill_idx       (fill_idx),
        .i_fill_valid   (i_fill_valid),
        .d_fill_valid   (d_fill_valid),
        .i_done         (i_done),
        .d_done         (d_done),
        .d_wr_ack       (d_wr_ack)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    txn_t        expq[$];
    int unsigned iss_k = 0, rx_k = 0, start_exp = 0;
    int unsigned last_done_cyc = 0;
    logic [15:0] last_issue_addr = '0;

    int unsigned lat = 4;
    bit          inject = 1'b0;
    logic [15:0] mq_addr[$];
    int unsigned mq_due[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_idx,
                    i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack});
    endfunction

    function automatic txn_t make_txn(input int k, input logic [15:0] ia, input logic [15:0] da,
                                      input logic [15:0] wa, input logic [15:0] wd);
        txn_t t;
        t.kind = k;
        t.addr = (k == K_I) ? ia : ((k == K_D) ? da : wa);
        t.data = wd;
        return t;
    endfunction

    // Memory: each read issue is answered lat cycles later, in order.
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = '0;
        forever begin
            @(negedge clk);
            if (mem_enable && !mem_wr) begin
                mq_addr.push_back(mem_addr);
                mq_due.push_back(cyc + lat);
            end
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                mem_data_valid = 1'b1;
                mem_data_out   = mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                mem_data_valid = inject && ($urandom_range(0, 1) == 1);
                mem_data_out   = 16'($urandom);
            end
        end
    end

    // Monitor
    initial begin
        logic        fill_act;
        logic [15:0] base;
        logic [1:0]  own;
        logic        last;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("reset_outputs", all_outs(), 64'd0);
                expq.delete();
                iss_k = 0;
                rx_k  = 0;
            end else begin
                fill_act = (expq.size() > 0) && (expq[0].kind != K_W);
                base     = (expq.size() > 0) ? (expq[0].addr & 16'hFFF0) : 16'h0;
                if (mem_enable && !mem_wr) begin
                    if (!fill_act || iss_k >= 8) begin
                        check("unexpected_issue", {mem_enable, mem_wr}, 2'b00);
                    end else begin
                        if (iss_k == 0) check("fill_start_cycle", cyc, start_exp);
                        check("issue_addr", mem_addr, base + 16'(2 * iss_k));
                        check("issue_wdata_ack", {d_wr_ack, mem_data_in}, 17'd0);
                        last_issue_addr = mem_addr;
                        iss_k++;
                    end
                end else if (mem_enable && mem_wr) begin
                    if (expq.size() > 0 && expq[0].kind == K_W && iss_k == 0) begin
                        check("write_cycle", cyc, start_exp);
                        check("write_addr", mem_addr, expq[0].addr);
                        check("write_data", mem_data_in, expq[0].data);
                        check("write_ack", d_wr_ack, 1'b1);
                        void'(expq.pop_front());
                        start_exp = cyc + 2;
                    end else begin
                        check("unexpected_write", {mem_enable, mem_wr}, 2'b00);
                    end
                end else begin
                    check("idle_bus", {mem_wr, mem_addr, mem_data_in, d_wr_ack}, 34'd0);
                end

                fill_act = (expq.size() > 0) && (expq[0].kind != K_W);
                if (mem_data_valid && fill_act && rx_k < iss_k) begin
                    own  = (expq[0].kind == K_I) ? 2'b10 : 2'b01;
                    last = (rx_k == 7);
                    check("fill_flags", {i_fill_valid, d_fill_valid, i_done, d_done},
                          {own, last ? own : 2'b00});
                    check("fill_idx", fill_idx, 3'(rx_k));
                    check("fill_data", fill_data, mem_word(base + 16'(2 * rx_k)));
                    rx_k++;
                    if (last) begin
                        void'(expq.pop_front());
                        iss_k         = 0;
                        rx_k          = 0;
                        start_exp     = cyc + 2;
                        last_done_cyc = cyc;
                    end
                end else begin
                    check("no_fill", {i_fill_valid, d_fill_valid, i_done, d_done}, 4'd0);
                end
            end
        end
    end

    task automatic run_round(input bit w, input bit d, input bit i, input int late, input bit drop_first,
                             input logic [15:0] ia, input logic [15:0] da,
                             input logic [15:0] wa, input logic [15:0] wd,
                             output int unsigned t_start);
        bit          pend[3];
        int          first;
        int unsigned n;
        pend[K_I] = i;
        pend[K_D] = d;
        pend[K_W] = w;
        first = w ? K_W : (d ? K_D : K_I);
        if (late >= 0) pend[late] = 1'b1;
        expq.push_back(make_txn(first, ia, da, wa, wd));
        pend[first] = 1'b0;
        for (int k = K_W; k >= K_I; k--) begin
            if (pend[k]) expq.push_back(make_txn(k, ia, da, wa, wd));
        end
        @(negedge clk);
        #3;
        t_start   = cyc + 1;
        start_exp = t_start;
        i_addr    = ia;
        d_addr    = da;
        d_wr_addr = wa;
        d_wr_data = wd;
        i_req     = i;
        d_req     = d;
        d_wr_req  = w;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
            if (i_done)   i_req    = 1'b0;
            if (d_done)   d_req    = 1'b0;
            if (d_wr_ack) d_wr_req = 1'b0;
            if (n == 3 && drop_first) begin
                if (first == K_I) i_req = 1'b0;
                if (first == K_D) d_req = 1'b0;
            end
            if (n == 3 && late == K_I) i_req = 1'b1;
            if (n == 3 && late == K_D) d_req = 1'b1;
            if (n == 3 && late == K_W) d_wr_req = 1'b1;
        end while ((expq.size() != 0 || i_req || d_req || d_wr_req) && n < 400);
        check("round_pending", expq.size(), 0);
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_wr_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ts;
        int unsigned n;
        bit          w, d, i, drop;
        int          late, k;

        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Lone I fill, latency 4
        lat = 4;
        run_round(0, 0, 1, -1, 0, 16'h1236, 16'h0, 16'h0, 16'h0, ts);
        check("lat4_done_offset", last_done_cyc - ts, 11);

        // Simultaneous D and I
        lat = 2;
        run_round(0, 1, 1, -1, 0, 16'h4404, 16'h8812, 16'h0, 16'h0, ts);

        // Write arriving during an I fill
        lat = 3;
        run_round(0, 0, 1, K_W, 0, 16'h2468, 16'h0, 16'h0040, 16'hBEEF, ts);

        // Reset in the middle of a fill
        lat = 3;
        expq.push_back(make_txn(K_I, 16'h2004, 16'h0, 16'h0, 16'h0));
        @(negedge clk);
        #3;
        start_exp = cyc + 1;
        i_addr    = 16'h2004;
        i_req     = 1'b1;
        n = 0;
        while (rx_k < 3 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("rst_reach_word3", rx_k, 3);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check("rst_async_clear", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_round(0, 1, 0, -1, 0, 16'h0, 16'h3A5C, 16'h0, 16'h0, ts);

        // Top-of-memory block, done while still issuing (zero latency) and latency 1
        lat = 0;
        run_round(0, 1, 0, -1, 0, 16'h0, 16'hFFF8, 16'h0, 16'h0, ts);
        check("lat0_done_offset", last_done_cyc - ts, 7);
        check("lat0_last_issue", last_issue_addr, 16'hFFFE);
        lat = 1;
        run_round(0, 1, 0, -1, 0, 16'h0, 16'hFFF8, 16'h0, 16'h0, ts);
        check("lat1_done_offset", last_done_cyc - ts, 8);
        check("lat1_last_issue", last_issue_addr, 16'hFFFE);

        // Randomized rounds with idle-time stray memory pulses
        repeat (30) begin
            lat = $urandom_range(0, 5);
            do begin
                {w, d, i} = 3'($urandom);
            end while ({w, d, i} == 3'b000);
            late = -1;
            if (!w && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 2));
                if ((k == K_I && !i) || (k == K_D && !d) || k == K_W) late = k;
            end
            drop = !w && ($urandom_range(0, 3) == 0);
            run_round(w, d, i, late, drop, 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), ts);
            inject = 1'b1;
            repeat (4) @(negedge clk);
            #3 inject = 1'b0;
            repeat (2) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
